// File: rtl/psum_pkg.sv
// Shared sizing and FSM state encoding for the PSUM readout path.
// Pure declarations; no logic, so no latency or backpressure of its own.
// Sizes match the SFP write-back datapath.
package psum_pkg;

    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int ADDR_BW = 11;
    localparam int ROW_BW  = COL * PSUM_BW;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/readout_fifo2.sv
// Two-entry row buffer that absorbs the SRAM read latency under output stalls.
// Latency: a pushed row appears at head the cycle after the push edge.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module readout_fifo2
    import psum_pkg::*;
#(
    parameter int width = ROW_BW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [1:0]       occ,
    output logic [width-1:0] head
);

    logic [width-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == 2'd2);
    assign empty   = (occ == 2'd0);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the push lands in, so push-at-full is safe when popping.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/psum_readout.sv
// Streams num_rows consecutive PSUM SRAM rows from base_addr to the output port.
// Latency: start at edge 0 -> first read in cycle 1 -> out_valid from cycle 3; 1 row/cycle.
// Backpressure: reads are issued only while buffer + in-flight rows leave room after this cycle's pop.
module psum_readout
    import psum_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int addr_bw = ADDR_BW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       base_addr,
    input  logic [addr_bw-1:0]       num_rows,
    output logic                     busy,
    output logic                     done,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [addr_bw-1:0]       sram_addr,
    input  logic [col*psum_bw-1:0]   sram_q,
    output logic [col*psum_bw-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready
);

    state_t             state;
    state_t             state_nxt;
    logic [addr_bw-1:0] rd_left;
    logic               inflight;
    logic               issue;
    logic               pop;
    logic               credit_ok;
    logic [1:0]         occ;
    logic               full;
    logic               empty;

    assign pop       = out_valid & out_ready;
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    assign issue     = (state == READ) && (rd_left != '0) && credit_ok;

    assign sram_cen  = ~issue;
    assign sram_wen  = 1'b1;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_valid = ~empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_rows == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (rd_left == '0) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Finish as the last buffered row leaves, so done lands the next cycle.
                if (!inflight && (empty || (occ == 2'd1 && pop))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_left   <= '0;
            sram_addr <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (state == IDLE && start && num_rows != '0) begin
                sram_addr <= base_addr;
                rd_left   <= num_rows;
            end else if (issue) begin
                sram_addr <= sram_addr + addr_bw'(1);
                rd_left   <= rd_left - addr_bw'(1);
            end
        end
    end

    readout_fifo2 #(
        .width (col * psum_bw)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (sram_q),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .occ       (occ),
        .head      (out_data)
    );

    // Credit logic guarantees a returning read always finds a free slot.
    no_overflow: assert property (@(posedge clk) disable iff (reset) !(full && inflight && !pop));

endmodule

// File: tb/tb_psum_readout.sv
// Randomized bench for psum_readout: an SRAM model plus a scoreboard of expected rows and
// read addresses, filled at start time and drained by an independent output monitor.
module tb_psum_readout;
    import psum_pkg::*;

    localparam int RB = ROW_BW;
    localparam int AW = ADDR_BW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_rows = '0;
    logic          busy;
    logic          done;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [RB-1:0] sram_q;
    logic [RB-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    psum_readout dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_q    (sram_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // SRAM model: data only valid the cycle after a read; garbage otherwise.
    logic [RB-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!sram_cen) sram_q <= mem[sram_addr];
        else           sram_q <= {$urandom, $urandom, $urandom, $urandom};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [RB-1:0] exp_rows[$];
    logic [AW-1:0] exp_addrs[$];
    int issued = 0, popped = 0;
    int done_cnt = 0, exp_done = 0;
    int first_cen = -1, first_vld = -1, last_pop = -1, done_cyc = -1;
    int xfer_rows = 0;
    int rdy_mode = 0;

    task automatic chk(input string name, input logic [RB-1:0] act, input logic [RB-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Ready generator: 0 always, 1 fixed 1,0,0,1,0,1 pattern, 2 random, 3 stalled.
    initial begin
        logic [5:0] pat;
        int phase;
        pat = 6'b101001;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       begin out_ready = pat[phase]; phase = (phase + 1) % 6; end
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops, address order, credit rule, hold stability, done timing.
    logic          hold_pend = 1'b0;
    logic [RB-1:0] held;
    logic          done_prev = 1'b0;
    always @(negedge clk) begin : mon
        logic p;
        int   outst;
        if (reset) begin
            hold_pend = 1'b0;
            done_prev = 1'b0;
        end else begin
            p     = out_valid && out_ready;
            outst = issued - popped;
            if (hold_pend) begin
                chk("hold_valid", RB'(out_valid), RB'(1));
                chk("hold_data", out_data, held);
            end
            hold_pend = out_valid && !out_ready;
            held      = out_data;
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (!sram_cen) begin
                chk("credit", RB'((outst - int'(p)) < 2), RB'(1));
                chk("wen", RB'(sram_wen), RB'(1));
                if (exp_addrs.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_read: got addr %0h, none required (cycle %0d)", sram_addr, cyc);
                end else begin
                    chk("addr", RB'(sram_addr), RB'(exp_addrs.pop_front()));
                end
                issued++;
                if (first_cen < 0) first_cen = cyc;
            end
            if (p) begin
                if (exp_rows.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_row: got %0h, none required (cycle %0d)", out_data, cyc);
                end else begin
                    chk("row", out_data, exp_rows.pop_front());
                end
                popped++;
                last_pop = cyc;
            end
            if (done) begin
                chk("done_single", RB'(done_prev), RB'(0));
                if (xfer_rows > 0) begin
                    chk("done_after_pop", RB'(cyc - last_pop), RB'(1));
                    chk("done_rows_left", RB'(exp_rows.size()), RB'(0));
                end
                done_cnt++;
                done_cyc = cyc;
            end
            done_prev = done;
        end
    end

    task automatic run_xfer(input logic [AW-1:0] base, input logic [AW-1:0] n, output int s);
        int k;
        k = 0;
        while (busy && k < 2000) begin @(posedge clk); #1; k++; end
        if (busy) chk("idle_before_start", RB'(busy), RB'(0));
        for (int i = 0; i < int'(n); i++) begin
            exp_addrs.push_back(AW'(int'(base) + i));
            exp_rows.push_back(mem[AW'(int'(base) + i)]);
        end
        xfer_rows = int'(n);
        first_cen = -1;
        first_vld = -1;
        exp_done++;
        start = 1'b1; base_addr = base; num_rows = n;
        @(posedge clk);
        #1;
        s = cyc;
        start = 1'b0;
        base_addr = AW'($urandom);
        num_rows  = AW'($urandom);
    endtask

    task automatic wait_end(input int limit);
        int k;
        k = 0;
        while (busy && k < limit) begin @(posedge clk); #1; k++; end
        chk("xfer_finished", RB'(busy), RB'(0));
        chk("rows_left", RB'(exp_rows.size()), RB'(0));
        chk("addrs_left", RB'(exp_addrs.size()), RB'(0));
    endtask

    initial begin
        int s;
        int iss0;
        for (int a = 0; a < (1 << AW); a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) mem[16 + i] = {COL{16'h0100 + 16'(i)}};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", RB'(busy), RB'(0));
        chk("rst_done", RB'(done), RB'(0));
        chk("rst_cen", RB'(sram_cen), RB'(1));
        chk("rst_wen", RB'(sram_wen), RB'(1));
        chk("rst_addr", RB'(sram_addr), RB'(0));
        chk("rst_valid", RB'(out_valid), RB'(0));
        chk("rst_data", out_data, RB'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic: full-rate stream with exact latency and done timing.
        rdy_mode = 0;
        run_xfer(AW'(16), AW'(4), s);
        wait_end(100);
        chk("lat_first_read", RB'(first_cen), RB'(s));
        chk("lat_first_valid", RB'(first_vld), RB'(s + 2));
        chk("done_cycle", RB'(done_cyc), RB'(s + 6));
        chk("done_count_basic", RB'(done_cnt), RB'(exp_done));

        // Backpressure with the fixed ready pattern.
        rdy_mode = 1;
        run_xfer(AW'($urandom), AW'(6), s);
        wait_end(200);

        // Zero rows: no reads, no data, done in cycle 1.
        rdy_mode = 0;
        iss0 = issued;
        run_xfer(AW'($urandom), AW'(0), s);
        wait_end(20);
        chk("zero_no_reads", RB'(issued - iss0), RB'(0));
        chk("zero_no_valid", RB'(first_vld), RB'(-1));
        chk("zero_done_cycle", RB'(done_cyc), RB'(s));

        // Address wrap.
        rdy_mode = 2;
        run_xfer(AW'(11'h7FE), AW'(4), s);
        wait_end(200);

        // Start while busy is ignored.
        run_xfer(AW'(11'h200), AW'(8), s);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = AW'(11'h300); num_rows = AW'(5);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_end(300);
        chk("done_count_busy", RB'(done_cnt), RB'(exp_done));

        // Reset mid-transfer with the buffer full.
        rdy_mode = 3;
        run_xfer(AW'($urandom), AW'(8), s);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", RB'(out_valid), RB'(0));
        chk("midrst_cen", RB'(sram_cen), RB'(1));
        chk("midrst_busy", RB'(busy), RB'(0));
        exp_rows.delete();
        exp_addrs.delete();
        issued = 0;
        popped = 0;
        exp_done--;
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdy_mode = 0;
        run_xfer(AW'($urandom), AW'(5), s);
        wait_end(200);

        // Random transfers.
        for (int t = 0; t < 12; t++) begin
            rdy_mode = $urandom_range(0, 2);
            run_xfer(AW'($urandom), AW'($urandom_range(1, 12)), s);
            wait_end(400);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("done_count_total", RB'(done_cnt), RB'(exp_done));
        chk("final_busy", RB'(busy), RB'(0));
        chk("final_valid", RB'(out_valid), RB'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

endmodule
